mux_stream_n: RTL and testbench
===============================

MUX_STREAM_N -- requirements
Module: mux_stream_n

Interface
REQ-001 Parameter WIDTH, default 8: data width of every channel and of the output.
REQ-002 Parameter CHANNELS, default 4, legal range 2..16: number of input channels; SEL_W = max(1, clog2(CHANNELS)) is derived.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 in_valid  input  CHANNELS  per-channel valid.
REQ-007 in_ready  output  CHANNELS  per-channel ready, combinational.
REQ-008 sel  input  SEL_W  channel select, used only in select mode.
REQ-009 out_data  output  WIDTH  registered output data.
REQ-010 out_valid  output  1  registered output valid.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 xfer_count  output  16  count of completed output transfers.

Function
REQ-013 Output stage has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 load = !out_valid || out_ready; the stage accepts a new word only when load=1.
REQ-015 Chosen channel c is decided combinationally each cycle (see REQ-027/028); in_ready[c] = load, all other in_ready bits = 0.
REQ-016 Input transfer occurs when in_valid[c] && in_ready[c]; in that cycle out_data <= in_data[c], out_valid <= 1.
REQ-017 Latency: word accepted at edge N is presented on out_data/out_valid after edge N, i.e. 1 cycle.
REQ-018 Output transfer occurs when out_valid && out_ready; if no input transfer in the same cycle, out_valid <= 0 (FULL->EMPTY).
REQ-019 Simultaneous output and input transfer: stage stays FULL, new word replaces old, no bubble; full throughput of one word per cycle.
REQ-020 FULL with out_ready=0: out_data and out_valid hold; all in_ready = 0.
REQ-021 EMPTY with in_valid[c]=0: stage stays EMPTY; out_data holds last value.
REQ-022 xfer_count increments by 1 on each output transfer, wraps 16'hFFFF -> 0.
REQ-023 In select mode, sel >= CHANNELS selects no channel: all in_ready = 0, no input transfer.
REQ-024 Unselected channels are never consumed regardless of in_valid.

Reset
REQ-025 While rst=1: out_valid=0, out_data=0, xfer_count=0, round-robin pointer=CHANNELS-1, all in_ready=0.
REQ-026 Reset asserted mid-transfer discards the held word immediately (asynchronously); first accept occurs on the first rising edge after rst deasserts.

Configuration
REQ-027 Without MUX_STREAM_RR_EN: c = sel (select mode), sel sampled combinationally in the accept cycle.
REQ-028 With MUX_STREAM_RR_EN defined: sel is ignored; c = first channel with in_valid=1 searching from pointer+1 upward modulo CHANNELS; on each input transfer pointer <= c; if no channel valid, no channel is chosen and pointer holds.
REQ-029 Port list and parameters are identical in both builds.

Verification (WIDTH=8, CHANNELS=4)
REQ-030 Select mode, sel=1, in_data ch0=216 ch1=20, in_valid=4'b0011, out_ready=1 -> in_ready=4'b0010; next cycle out_data=20, out_valid=1; xfer_count=1 after following edge.
REQ-031 Stall: out_valid=1 holding 63, out_ready=0 for 3 cycles, ch2 valid with 202 -> out_data stays 63, in_ready=0; on out_ready=1 same cycle ch2 accepted, next cycle out_data=202.
REQ-032 Back-to-back: sel=3, ch3 presents 231,185,229,84 on consecutive cycles, out_ready=1 -> four outputs in order, one per cycle, xfer_count=4.
REQ-033 sel=3'd? out of range not possible at CHANNELS=4; use CHANNELS=3 build, sel=3 -> in_ready=0, out_valid stays 0 for 5 cycles.
REQ-034 MUX_STREAM_RR_EN, all four channels valid continuously, out_ready=1 -> grant order 0,1,2,3,0; with only ch2 valid -> ch2 granted every cycle.
REQ-035 Assert rst while out_valid=1 and xfer_count=7 -> out_valid=0, out_data=0, xfer_count=0 before next clock edge; RR build restarts at channel 0.

Source files
------------

// File: rtl/mux_stream_n.sv
// mux_stream_n: CHANNELS-input stream multiplexer feeding a one-deep registered
// output stage (EMPTY/FULL) that sustains one word per cycle.
// Build option: define MUX_STREAM_RR_EN to replace sel-based channel choice with
// round-robin arbitration among valid channels (sel is then ignored).
module mux_stream_n #(
  parameter int unsigned  WIDTH    = 8,
  parameter int unsigned  CHANNELS = 4,
  localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               xfer_count
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [15:0]      count_nxt;
  logic [SEL_W-1:0] chosen;
  logic             hit;
  logic             load;
  logic             take;
  logic [WIDTH-1:0] chosen_data;
  logic             chosen_valid;

`ifdef MUX_STREAM_RR_EN
  logic [SEL_W-1:0] ptr;
  logic             unused_sel;
  int unsigned      dist;
  int unsigned      best;

  assign unused_sel = ^sel;

  // Round-robin: pick the valid channel closest after the last granted one
  always_comb begin
    hit    = 1'b0;
    chosen = '0;
    dist   = 0;
    best   = CHANNELS;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      dist = (32'(k) + CHANNELS - 32'd1 - 32'(ptr)) % CHANNELS;
      if (in_valid[k] && (dist < best)) begin
        best   = dist;
        chosen = SEL_W'(k);
        hit    = 1'b1;
      end
    end
  end

  // Pointer remembers the last channel that completed an input transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SEL_W'(CHANNELS - 1);
    end else if (take) begin
      ptr <= chosen;
    end
  end
`else
  assign chosen = sel;

  // Out-of-range select codes exist only when CHANNELS is not a power of two
  generate
    if (CHANNELS == (1 << SEL_W)) begin : g_full_range
      assign hit = 1'b1;
    end else begin : g_part_range
      assign hit = (sel < SEL_W'(CHANNELS));
    end
  endgenerate
`endif

  // Mux the chosen channel's payload and valid
  always_comb begin
    chosen_data  = '0;
    chosen_valid = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (chosen == SEL_W'(k)) begin
        chosen_data  = in_data[k*WIDTH +: WIDTH];
        chosen_valid = in_valid[k];
      end
    end
  end

  assign load = (state == EMPTY) || out_ready;
  assign take = hit && load && chosen_valid;

  // Only the chosen channel sees ready, and only when the stage can load
  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      in_ready[k] = !rst && load && hit && (chosen == SEL_W'(k));
    end
  end

  // Output stage next-state: load on input transfer, drain on output transfer
  always_comb begin
    state_nxt = state;
    data_nxt  = out_data;
    count_nxt = xfer_count;
    case (state)
      EMPTY: begin
        if (take) begin
          state_nxt = FULL;
          data_nxt  = chosen_data;
        end
      end
      FULL: begin
        if (out_ready) begin
          count_nxt = xfer_count + 16'd1;
        end
        if (take) begin
          data_nxt = chosen_data;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Output stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_data   <= '0;
      xfer_count <= '0;
    end else begin
      state      <= state_nxt;
      out_data   <= data_nxt;
      xfer_count <= count_nxt;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux_stream_n.sv
// tb_mux_stream_n: table-driven check of mux_stream_n (WIDTH=8, CHANNELS=4) with a
// word scoreboard, plus a CHANNELS=3 instance for out-of-range select.
module tb_mux_stream_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_count;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [15:0] xfer_count3;

  mux_stream_n #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_count(xfer_count)
  );

  mux_stream_n #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .xfer_count(xfer_count3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          n_pops = 0;
  logic [7:0]  last_pop = 8'd0;
  logic [7:0]  q[$];
  vec_t        tab_a[$];
  vec_t        tab_b[$];

  function automatic vec_t mk(input logic [1:0] s, input logic [3:0] v,
                              input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0,
                              input logic r, input logic [3:0] er);
    vec_t t;
    t.sel = s; t.vld = v; t.data = {d3, d2, d1, d0}; t.ordy = r; t.exp_rdy = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one row after the edge, then compare and update the scoreboard mid-cycle
  task automatic run_vec(input vec_t v);
    logic [7:0] w;
    @(posedge clk); #1;
    sel = v.sel; in_valid = v.vld; in_data = v.data; out_ready = v.ordy;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("xfer_count", 32'(xfer_count), 32'(n_pops));
    chk("in_ready", 32'(in_ready), 32'(v.exp_rdy));
    if (q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(q[0]));
      if (v.ordy) begin
        last_pop = q.pop_front();
        n_pops++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (v.exp_rdy[k] && v.vld[k]) begin
        w = v.data[k*8 +: 8];
        q.push_back(w);
      end
    end
  endtask

  initial begin
`ifdef MUX_STREAM_RR_EN
    tab_a.push_back(mk(3, 4'b1111, 13, 12, 11, 10, 1, 4'b0001));
    tab_a.push_back(mk(3, 4'b1111, 13, 12, 11, 10, 1, 4'b0010));
    tab_a.push_back(mk(3, 4'b1111, 13, 12, 11, 10, 1, 4'b0100));
    tab_a.push_back(mk(3, 4'b1111, 13, 12, 11, 10, 1, 4'b1000));
    tab_a.push_back(mk(3, 4'b1111, 13, 12, 11, 10, 1, 4'b0001));
    tab_a.push_back(mk(0, 4'b0100, 13, 42, 11, 10, 1, 4'b0100));
    tab_a.push_back(mk(0, 4'b0100, 13, 43, 11, 10, 1, 4'b0100));
    tab_a.push_back(mk(0, 4'b0100, 13, 44, 11, 10, 1, 4'b0100));
    tab_a.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000));
    tab_a.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000));
    tab_a.push_back(mk(1, 4'b0001, 0, 0, 0, 99, 0, 4'b0001));
    tab_b.push_back(mk(3, 4'b1111, 13, 12, 11, 5, 1, 4'b0001));
    tab_b.push_back(mk(3, 4'b0000, 0, 0, 0, 0, 1, 4'b0000));
    tab_b.push_back(mk(3, 4'b0000, 0, 0, 0, 0, 1, 4'b0000));
`else
    tab_a.push_back(mk(1, 4'b0011, 0, 0, 20, 216, 1, 4'b0010));
    tab_a.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 1, 4'b0010));
    tab_a.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 1, 4'b0010));
    tab_a.push_back(mk(0, 4'b0001, 0, 0, 0, 63, 0, 4'b0001));
    tab_a.push_back(mk(2, 4'b0100, 0, 202, 0, 0, 0, 4'b0000));
    tab_a.push_back(mk(2, 4'b0100, 0, 202, 0, 0, 0, 4'b0000));
    tab_a.push_back(mk(2, 4'b0100, 0, 202, 0, 0, 0, 4'b0000));
    tab_a.push_back(mk(2, 4'b0100, 0, 202, 0, 0, 1, 4'b0100));
    tab_a.push_back(mk(2, 4'b0000, 0, 0, 0, 0, 1, 4'b0100));
    tab_a.push_back(mk(3, 4'b1000, 231, 0, 0, 0, 1, 4'b1000));
    tab_a.push_back(mk(3, 4'b1000, 185, 0, 0, 0, 1, 4'b1000));
    tab_a.push_back(mk(3, 4'b1000, 229, 0, 0, 0, 1, 4'b1000));
    tab_a.push_back(mk(3, 4'b1000, 84, 0, 0, 0, 1, 4'b1000));
    tab_a.push_back(mk(3, 4'b0000, 0, 0, 0, 0, 1, 4'b1000));
    tab_a.push_back(mk(3, 4'b0000, 0, 0, 0, 0, 1, 4'b1000));
    tab_a.push_back(mk(0, 4'b0001, 0, 0, 0, 99, 0, 4'b0001));
    tab_b.push_back(mk(1, 4'b0010, 0, 0, 5, 0, 1, 4'b0010));
    tab_b.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 1, 4'b0010));
    tab_b.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 1, 4'b0010));
`endif

    rst = 1'b1;
    sel = 2'd0; in_valid = 4'hF; in_data = 32'h01020304; out_ready = 1'b1;
    sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h112233; out_ready3 = 1'b1;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 4'h0;

`ifndef MUX_STREAM_RR_EN
    // sel beyond CHANNELS-1 on the 3-channel instance must never accept
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("oor_in_ready", 32'(in_ready3), 32'd0);
      chk("oor_out_valid", 32'(out_valid3), 32'd0);
    end
`endif

    foreach (tab_a[i]) run_vec(tab_a[i]);
    chk("hold_data", 32'(out_data), 32'(last_pop));

    // Asynchronous reset while a word is held
    @(posedge clk); #1;
    in_valid = 4'h0; out_ready = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_count", 32'(xfer_count), 32'(n_pops));
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_xfer_count", 32'(xfer_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    n_pops = 0;
    @(negedge clk);
    rst = 1'b0;

    foreach (tab_b[i]) run_vec(tab_b[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
